ltc2656_spi_driver: RTL

Serializes DAC commands from the AXI DAC control register block into 24-bit SPI frames for the LTC2656 octal DAC. Drives the LDAC and CLR strobes as timed active-low pulses. Sits directly downstream of the control block and drives the board pins. Buffers one command while a frame is in flight, because the upstream start strobe has no back-pressure.

---
 rtl/ltc2656_pkg.sv | 33 +++
 rtl/ltc2656_pulse_gen.sv | 39 +++
 rtl/ltc2656_spi_driver.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ltc2656_pkg.sv
// Shared command codes, frame constants and FSM state type for the LTC2656 SPI driver.
package ltc2656_pkg;

    localparam logic [3:0] WRITE_N          = 4'h0;
    localparam logic [3:0] UPDATE_N         = 4'h1;
    localparam logic [3:0] WRITE_UPDATE_ALL = 4'h2;
    localparam logic [3:0] WRITE_UPDATE_N   = 4'h3;
    localparam logic [3:0] PWRDN_N          = 4'h4;
    localparam logic [3:0] PWRDN_CHIP       = 4'h5;
    localparam logic [3:0] INT_REF          = 4'h6;
    localparam logic [3:0] EXT_REF          = 4'h7;
    localparam logic [3:0] NOP              = 4'hF;

    localparam logic [3:0] CH_ALL = 4'hF;

    localparam int FRAME_BITS = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } spi_state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [3:0]  cmd,
        input logic [3:0]  channel,
        input logic [15:0] value
    );
        return {cmd, channel, value};
    endfunction

endpackage

// File: rtl/ltc2656_pulse_gen.sv
// Retriggerable active-low pulse timer: a trigger in cycle t drives pulse_n low
// for cycles t+1 through t+WIDTH; a new trigger restarts the count.
module ltc2656_pulse_gen #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic pulse_n
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_n_q, pulse_n_d;

    always_comb begin
        cnt_d = cnt_q;
        if (trigger) begin
            cnt_d = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        pulse_n_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pulse_n_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            pulse_n_q <= pulse_n_d;
        end
    end

    assign pulse_n = pulse_n_q;

endmodule

// File: rtl/ltc2656_spi_driver.sv
// LTC2656 SPI frame serializer with a one-deep command buffer and LDAC/CLR strobes.
// Define LTC2656_READBACK_EN to add SDO capture (SPI_SDO, rb_word, rb_valid).
module ltc2656_spi_driver
    import ltc2656_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int LDAC_PULSE = 4,
    parameter int CLR_PULSE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  dac_cmd,
    input  logic [3:0]  dac_channel,
    input  logic [15:0] dac_value,
    input  logic        dac_start,
    input  logic        dac_ldac,
    input  logic        dac_clr,
    output logic        busy,
    output logic        overrun,
    output logic        SPI_SCK,
    output logic        SPI_SDI,
    output logic        SPI_CS_LD_N,
    output logic        DAC_LDAC_N,
    output logic        DAC_CLR_N
`ifdef LTC2656_READBACK_EN
    ,
    input  logic                  SPI_SDO,
    output logic [FRAME_BITS-1:0] rb_word,
    output logic                  rb_valid
`endif
);

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]        BIT_LAST = 5'(FRAME_BITS - 1);

    spi_state_e            state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [4:0]            bit_q, bit_d;
    logic                  sck_q, sck_d;
    logic                  cs_n_q, cs_n_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [FRAME_BITS-1:0] pend_frame_q, pend_frame_d;
    logic                  overrun_q, overrun_d;
    logic                  ldac_def_q, ldac_def_d;

    logic [FRAME_BITS-1:0] new_frame;
    logic                  consume;
    logic                  direct_load;
    logic                  ldac_now;
    logic                  ldac_fire;

    assign new_frame = build_frame(dac_cmd, dac_channel, dac_value);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sck_d        = sck_q;
        cs_n_d       = cs_n_q;
        shift_d      = shift_q;
        pend_valid_d = pend_valid_q;
        pend_frame_d = pend_frame_q;
        overrun_d    = 1'b0;
        consume      = 1'b0;
        direct_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    consume = 1'b1;
                    shift_d = pend_frame_q;
                end else if (dac_start) begin
                    direct_load = 1'b1;
                    shift_d     = new_frame;
                end
                if (pend_valid_q || dac_start) begin
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                // Data advances on each SCK fall so it is stable before the next rise.
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end else begin
                    cnt_d = '0;
                    if (sck_q) begin
                        sck_d   = 1'b0;
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    end else if (bit_q == BIT_LAST) begin
                        cs_n_d  = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end else begin
                    cnt_d = '0;
                    if (pend_valid_q) begin
                        consume = 1'b1;
                        shift_d = pend_frame_q;
                        cs_n_d  = 1'b0;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A buffer being drained this cycle has room for the incoming start.
        if (consume) begin
            pend_valid_d = 1'b0;
        end
        if (dac_start && !direct_load) begin
            if (!pend_valid_q || consume) begin
                pend_valid_d = 1'b1;
                pend_frame_d = new_frame;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        ldac_now   = dac_ldac && cs_n_q && !pend_valid_q && !dac_start;
        ldac_fire  = ldac_now ||
                     (ldac_def_q && (state_q == ST_IDLE) && !pend_valid_q && !dac_start);
        ldac_def_d = ldac_def_q;
        if (dac_ldac && !ldac_now) begin
            ldac_def_d = 1'b1;
        end
        if (ldac_fire) begin
            ldac_def_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            sck_q        <= 1'b0;
            cs_n_q       <= 1'b1;
            shift_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_frame_q <= '0;
            overrun_q    <= 1'b0;
            ldac_def_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            sck_q        <= sck_d;
            cs_n_q       <= cs_n_d;
            shift_q      <= shift_d;
            pend_valid_q <= pend_valid_d;
            pend_frame_q <= pend_frame_d;
            overrun_q    <= overrun_d;
            ldac_def_q   <= ldac_def_d;
        end
    end

    ltc2656_pulse_gen #(.WIDTH(LDAC_PULSE)) u_ldac_pulse (
        .clk     (clk),
        .reset   (reset),
        .trigger (ldac_fire),
        .pulse_n (DAC_LDAC_N)
    );

    ltc2656_pulse_gen #(.WIDTH(CLR_PULSE)) u_clr_pulse (
        .clk     (clk),
        .reset   (reset),
        .trigger (dac_clr),
        .pulse_n (DAC_CLR_N)
    );

    assign busy        = (state_q != ST_IDLE) || pend_valid_q;
    assign overrun     = overrun_q;
    assign SPI_SCK     = sck_q;
    assign SPI_SDI     = shift_q[FRAME_BITS-1];
    assign SPI_CS_LD_N = cs_n_q;

`ifdef LTC2656_READBACK_EN
    logic [FRAME_BITS-1:0] rb_shift_q, rb_shift_d;
    logic [FRAME_BITS-1:0] rb_word_q, rb_word_d;
    logic                  rb_valid_q, rb_valid_d;

    // SDO is sampled alongside the DAC's own SCK rise; the word is published as CS_N rises.
    always_comb begin
        rb_shift_d = rb_shift_q;
        rb_word_d  = rb_word_q;
        rb_valid_d = 1'b0;
        if (sck_d && !sck_q) begin
            rb_shift_d = {rb_shift_q[FRAME_BITS-2:0], SPI_SDO};
        end
        if (cs_n_d && !cs_n_q) begin
            rb_word_d  = rb_shift_q;
            rb_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_shift_q <= '0;
            rb_word_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_shift_q <= rb_shift_d;
            rb_word_q  <= rb_word_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_word  = rb_word_q;
    assign rb_valid = rb_valid_q;
`endif

endmodule
